// File: rtl/iob_eth_tx_param.sv
// Ethernet transmit MAC: preamble, header, payload, optional pad and CRC-32 FCS
// serialised over MII (4-bit) or GMII (8-bit). Define IOB_ETH_TX_PAD_EN to pad short payloads.
`timescale 1ns/1ps

module iob_eth_tx_param #(
  parameter int PHY_DATA_W  = 4,
  parameter int BUF_ADDR_W  = 11,
  parameter int IFG_BYTES   = 12,
  parameter int MIN_PAYLOAD = 46
) (
  input  logic                  TX_CLK,
  input  logic                  tx_rst,
  input  logic                  send,
  input  logic [15:0]           nbytes,
  input  logic [47:0]           dest_mac_addr,
  input  logic [47:0]           src_mac_addr,
  output logic [BUF_ADDR_W-1:0] addr,
  input  logic [7:0]            data,
  output logic                  TX_EN,
  output logic [PHY_DATA_W-1:0] TX_DATA,
  output logic                  ready
);

  localparam int IFG_CYC = IFG_BYTES * 8 / PHY_DATA_W;
  localparam int IFG_W   = $clog2(IFG_BYTES * 2 + 1);
  localparam logic [IFG_W-1:0] IFG_LOAD = IFG_W'(IFG_CYC - 1);
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  localparam logic [7:0]  PRE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE = 8'hD5;

  if ((PHY_DATA_W != 4 && PHY_DATA_W != 8) || IFG_BYTES < 1 || MIN_PAYLOAD < 0
      || BUF_ADDR_W > 16) begin : g_bad_param
    $error("iob_eth_tx_param: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_HEADER,
    S_PAYLOAD,
`ifdef IOB_ETH_TX_PAD_EN
    S_PAD,
`endif
    S_FCS,
    S_IFG
  } state_t;

  state_t                  state_q, state_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [3:0]              ph_q, ph_d;
  logic [IFG_W-1:0]        ifg_q, ifg_d;
  logic [31:0]             crc_q, crc_d;
  logic [15:0]             nb_q, nb_d;
  logic [47:0]             dst_q, dst_d;
  logic [47:0]             src_q, src_d;
  logic                    tx_en_q, tx_en_d;
  logic [PHY_DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                    ready_q, ready_d;
`ifdef IOB_ETH_TX_PAD_EN
  logic [15:0]             pad_q, pad_d;
`endif

  logic [111:0]            hdr;
  logic [31:0]             fcs;
  logic [7:0]              cur_byte;
  logic [PHY_DATA_W-1:0]   sym;
  logic                    byte_last;
  logic                    last_in_state;
  logic                    crc_en;
  state_t                  after_payload;
  state_t                  next_state;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  assign hdr = {nb_q, src_q, dst_q};
  assign fcs = ~crc_q;

  // The generator state points at the symbol to be driven on the next edge,
  // so every PHY output is a flop and payload data is read one cycle early.
  always_comb begin
    case (state_q)
      S_PREAMBLE: cur_byte = (cnt_q == 16'd7) ? SFD_BYTE : PRE_BYTE;
      S_HEADER:   cur_byte = hdr[{cnt_q[3:0], 3'b000} +: 8];
      S_PAYLOAD:  cur_byte = data;
      S_FCS:      cur_byte = fcs[{cnt_q[1:0], 3'b000} +: 8];
      default:    cur_byte = 8'h00;
    endcase
  end

  if (PHY_DATA_W == 8) begin : g_gmii
    assign sym = cur_byte;
  end else begin : g_mii
    assign sym = (ph_q == 4'd1) ? cur_byte[7:4] : cur_byte[3:0];
  end

  assign byte_last = (PHY_DATA_W == 8) || (ph_q == 4'd1);

`ifdef IOB_ETH_TX_PAD_EN
  assign after_payload = (pad_q != 16'd0) ? S_PAD : S_FCS;
  assign crc_en = (state_q == S_HEADER) || (state_q == S_PAYLOAD) || (state_q == S_PAD);
`else
  assign after_payload = S_FCS;
  assign crc_en = (state_q == S_HEADER) || (state_q == S_PAYLOAD);
`endif

  always_comb begin
    last_in_state = 1'b0;
    next_state    = S_IDLE;
    case (state_q)
      S_PREAMBLE: begin
        last_in_state = (cnt_q == 16'd7);
        next_state    = S_HEADER;
      end
      S_HEADER: begin
        last_in_state = (cnt_q == 16'd13);
        next_state    = (nb_q != 16'd0) ? S_PAYLOAD : after_payload;
      end
      S_PAYLOAD: begin
        last_in_state = (cnt_q == nb_q - 16'd1);
        next_state    = after_payload;
      end
`ifdef IOB_ETH_TX_PAD_EN
      S_PAD: begin
        last_in_state = (cnt_q == pad_q - 16'd1);
        next_state    = S_FCS;
      end
`endif
      S_FCS: begin
        last_in_state = (cnt_q == 16'd3);
        next_state    = S_IFG;
      end
      default: begin
        last_in_state = 1'b0;
        next_state    = S_IDLE;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ph_d      = ph_q;
    ifg_d     = ifg_q;
    crc_d     = crc_q;
    nb_d      = nb_q;
    dst_d     = dst_q;
    src_d     = src_q;
    tx_en_d   = 1'b0;
    tx_data_d = '0;
`ifdef IOB_ETH_TX_PAD_EN
    pad_d     = pad_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (send) begin
          // First preamble symbol goes out on the accepting edge itself.
          state_d   = S_PREAMBLE;
          tx_en_d   = 1'b1;
          tx_data_d = PRE_BYTE[PHY_DATA_W-1:0];
          cnt_d     = (PHY_DATA_W == 8) ? 16'd1 : 16'd0;
          ph_d      = (PHY_DATA_W == 8) ? 4'd0 : 4'd1;
          crc_d     = 32'hFFFF_FFFF;
          nb_d      = nbytes;
          dst_d     = dest_mac_addr;
          src_d     = src_mac_addr;
`ifdef IOB_ETH_TX_PAD_EN
          pad_d     = (nbytes < 16'(MIN_PAYLOAD)) ? (16'(MIN_PAYLOAD) - nbytes) : 16'd0;
`endif
        end
      end
      S_IFG: begin
        if (ifg_q == '0) begin
          state_d = S_IDLE;
        end else begin
          ifg_d = ifg_q - IFG_W'(1);
        end
      end
      default: begin
        tx_en_d   = 1'b1;
        tx_data_d = sym;
        if (byte_last) begin
          if (crc_en) begin
            crc_d = crc_next(crc_q, cur_byte);
          end
          ph_d = 4'd0;
          if (last_in_state) begin
            state_d = next_state;
            cnt_d   = 16'd0;
            ifg_d   = IFG_LOAD;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          ph_d = ph_q + 4'd1;
        end
      end
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge TX_CLK or posedge tx_rst) begin
    if (tx_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      ph_q      <= 4'd0;
      ifg_q     <= '0;
      crc_q     <= 32'hFFFF_FFFF;
      nb_q      <= 16'd0;
      dst_q     <= 48'd0;
      src_q     <= 48'd0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      ready_q   <= 1'b1;
`ifdef IOB_ETH_TX_PAD_EN
      pad_q     <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ph_q      <= ph_d;
      ifg_q     <= ifg_d;
      crc_q     <= crc_d;
      nb_q      <= nb_d;
      dst_q     <= dst_d;
      src_q     <= src_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      ready_q   <= ready_d;
`ifdef IOB_ETH_TX_PAD_EN
      pad_q     <= pad_d;
`endif
    end
  end

  assign addr    = (state_q == S_PAYLOAD) ? cnt_q[BUF_ADDR_W-1:0] : '0;
  assign TX_EN   = tx_en_q;
  assign TX_DATA = tx_data_q;
  assign ready   = ready_q;

endmodule
